// File: rtl/traffic_pkg.sv
// Shared types and lane/phase helpers for the traffic signal subsystem.
package traffic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GREEN,
    YELLOW,
    ALLRED
  } state_e;

  localparam int unsigned MAX_LANES = 64;

  function automatic int unsigned lane_phase(input int unsigned lane,
                                             input int unsigned num_phases);
    return lane % num_phases;
  endfunction

  function automatic logic [MAX_LANES-1:0] phase_lane_mask(input int unsigned phase,
                                                           input int unsigned num_lanes,
                                                           input int unsigned num_phases);
    logic [MAX_LANES-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_LANES; i++) begin
      if (i < num_lanes && lane_phase(i, num_phases) == phase) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/traffic_phase_controller_arbiter.sv
// Combinational rotate-priority arbiter: first request after 'last', wrapping.
module phase_rr_arbiter #(
  parameter int unsigned N = 2,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [W-1:0] grant,
  output logic         any
);

  logic [W-1:0] sel;

  assign any = |req;

  // Walk offsets from farthest to nearest so offset 1 overrides everything.
  always_comb begin
    grant = '0;
    sel   = '0;
    for (int unsigned k = N; k >= 1; k--) begin
      sel = W'((32'(last) + k) % N);
      if (req[sel]) grant = sel;
    end
  end

endmodule

// File: rtl/traffic_phase_controller.sv
// Round-robin multi-phase intersection sequencer: GREEN -> YELLOW -> optional ALLRED,
// with per-phase demand latching and green rest while only the served phase has demand.
module traffic_phase_controller
  import traffic_pkg::*;
#(
  parameter int unsigned NUM_LANES   = 4,
  parameter int unsigned NUM_PHASES  = 2,
  parameter int unsigned GREEN_TIME  = 55,
  parameter int unsigned YELLOW_TIME = 10,
  parameter int unsigned ALLRED_TIME = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_LANES-1:0]          traffic,
  output logic [NUM_LANES-1:0]          red,
  output logic [NUM_LANES-1:0]          yellow,
  output logic [NUM_LANES-1:0]          green,
  output logic [$clog2(NUM_PHASES)-1:0] active_phase,
  output logic                          busy
);

  localparam int unsigned PW    = $clog2(NUM_PHASES);
  localparam int unsigned T_GY  = (GREEN_TIME > YELLOW_TIME) ? GREEN_TIME : YELLOW_TIME;
  localparam int unsigned T_MAX = (T_GY > ALLRED_TIME) ? T_GY : ALLRED_TIME;
  localparam int unsigned TW    = $clog2(T_MAX + 1);

  localparam logic [TW-1:0] GREEN_LOAD  = TW'(GREEN_TIME - 1);
  localparam logic [TW-1:0] YELLOW_LOAD = TW'(YELLOW_TIME - 1);
  localparam logic [TW-1:0] ALLRED_LOAD = TW'((ALLRED_TIME == 0) ? 0 : ALLRED_TIME - 1);

  state_e                state_q, state_d;
  logic [PW-1:0]         cur_q, cur_d;
  logic [PW-1:0]         last_q, last_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [NUM_PHASES-1:0] pend_q, pend_d;
  logic [NUM_LANES-1:0]  red_q, red_d;
  logic [NUM_LANES-1:0]  yellow_q, yellow_d;
  logic [NUM_LANES-1:0]  green_q, green_d;
  logic [PW-1:0]         active_phase_q, active_phase_d;
  logic                  busy_q, busy_d;

  logic [NUM_PHASES-1:0] dem, req, others;
  logic [PW-1:0]         grant;
  logic                  any_req;

  always_comb begin
    dem = '0;
    for (int unsigned p = 0; p < NUM_PHASES; p++) begin
      dem[p] = |(MAX_LANES'(traffic) & phase_lane_mask(p, NUM_LANES, NUM_PHASES));
    end
  end

  assign req    = pend_q | dem;
  assign others = req & ~(NUM_PHASES'(1) << cur_q);

  phase_rr_arbiter #(
    .N(NUM_PHASES),
    .W(PW)
  ) u_arb (
    .req  (req),
    .last (last_q),
    .grant(grant),
    .any  (any_req)
  );

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    last_d  = last_q;
    timer_d = timer_q;
    pend_d  = pend_q | dem;
    // The served phase's own demand is not remembered while it is green.
    if (state_q == GREEN) pend_d[cur_q] = pend_q[cur_q];

    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d       = GREEN;
          cur_d         = grant;
          timer_d       = GREEN_LOAD;
          pend_d[grant] = 1'b0;
        end
      end
      GREEN: begin
        if (timer_q != '0) begin
          timer_d = timer_q - TW'(1);
        end else if (|others || !dem[cur_q]) begin
          state_d = YELLOW;
          timer_d = YELLOW_LOAD;
        end
      end
      YELLOW: begin
        if (timer_q != '0) begin
          timer_d = timer_q - TW'(1);
        end else begin
          last_d = cur_q;
          if (ALLRED_TIME == 0) begin
            state_d = IDLE;
          end else begin
            state_d = ALLRED;
            timer_d = ALLRED_LOAD;
          end
        end
      end
      ALLRED: begin
        if (timer_q != '0) timer_d = timer_q - TW'(1);
        else               state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    red_d    = '1;
    yellow_d = '0;
    green_d  = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (PW'(lane_phase(i, NUM_PHASES)) == cur_d) begin
        if (state_d == GREEN) begin
          green_d[i] = 1'b1;
          red_d[i]   = 1'b0;
        end else if (state_d == YELLOW) begin
          yellow_d[i] = 1'b1;
          red_d[i]    = 1'b0;
        end
      end
    end
    busy_d         = (state_d != IDLE);
    active_phase_d = (state_d == GREEN || state_d == YELLOW) ? cur_d : last_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cur_q          <= '0;
      last_q         <= PW'(NUM_PHASES - 1);
      timer_q        <= '0;
      pend_q         <= '0;
      red_q          <= '1;
      yellow_q       <= '0;
      green_q        <= '0;
      active_phase_q <= '0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cur_q          <= cur_d;
      last_q         <= last_d;
      timer_q        <= timer_d;
      pend_q         <= pend_d;
      red_q          <= red_d;
      yellow_q       <= yellow_d;
      green_q        <= green_d;
      active_phase_q <= active_phase_d;
      busy_q         <= busy_d;
    end
  end

  assign red          = red_q;
  assign yellow       = yellow_q;
  assign green        = green_q;
  assign active_phase = active_phase_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Self-checking bench: default 2-phase controller against a segment-level model,
// plus a 4-phase no-clearance instance checked against scripted expectations.
module tb_traffic_phase_controller;

  localparam int G  = 55;
  localparam int Y  = 10;
  localparam int AR = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic [3:0] traffic_a, red_a, yellow_a, green_a;
  logic       active_a, busy_a;
  logic [7:0] traffic_b, red_b, yellow_b, green_b;
  logic [1:0] active_b;
  logic       busy_b;
  logic [13:0] dut_a;

  int n_checks = 0;
  int n_pass   = 0;

  traffic_phase_controller u_a (
    .clk(clk), .rst(rst_a), .traffic(traffic_a),
    .red(red_a), .yellow(yellow_a), .green(green_a),
    .active_phase(active_a), .busy(busy_a)
  );

  traffic_phase_controller #(
    .NUM_LANES(8), .NUM_PHASES(4), .GREEN_TIME(4), .YELLOW_TIME(3), .ALLRED_TIME(0)
  ) u_b (
    .clk(clk), .rst(rst_b), .traffic(traffic_b),
    .red(red_b), .yellow(yellow_b), .green(green_b),
    .active_phase(active_b), .busy(busy_b)
  );

  assign dut_a = {red_a, yellow_a, green_a, busy_a, active_a};

  // Segment-level model: what lamp segment is showing, for whom, and how many cycles remain.
  localparam int K_IDLE = 0, K_GREEN = 1, K_YELLOW = 2, K_ALLRED = 3;
  int     m_kind, m_phase, m_last, m_left;
  bit [1:0] m_pend;

  task automatic model_reset();
    m_kind = K_IDLE; m_phase = 0; m_last = 1; m_left = 0; m_pend = 2'b00;
  endtask

  task automatic model_advance(input logic [3:0] t);
    bit [1:0] dem, req, np;
    int sel;
    dem = {t[1] | t[3], t[0] | t[2]};
    req = m_pend | dem;
    np  = m_pend | dem;
    if (m_kind == K_GREEN) np[m_phase] = m_pend[m_phase];
    case (m_kind)
      K_IDLE: if (req != 0) begin
        sel = -1;
        for (int k = 1; k <= 2; k++) if (sel < 0 && req[(m_last + k) % 2]) sel = (m_last + k) % 2;
        m_kind = K_GREEN; m_phase = sel; m_left = G; np[sel] = 1'b0;
      end
      K_GREEN: begin
        if (m_left > 1) m_left--;
        else if (req[1 - m_phase] || !dem[m_phase]) begin m_kind = K_YELLOW; m_left = Y; end
      end
      K_YELLOW: begin
        if (m_left > 1) m_left--;
        else begin
          m_last = m_phase;
          if (AR > 0) begin m_kind = K_ALLRED; m_left = AR; end
          else m_kind = K_IDLE;
        end
      end
      default: begin
        if (m_left > 1) m_left--;
        else m_kind = K_IDLE;
      end
    endcase
    m_pend = np;
  endtask

  function automatic logic [13:0] exp_vec();
    logic [3:0] r, yy, g;
    r = 4'hF; yy = 4'h0; g = 4'h0;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == m_phase && m_kind == K_GREEN)  begin g[i]  = 1'b1; r[i] = 1'b0; end
      if (i % 2 == m_phase && m_kind == K_YELLOW) begin yy[i] = 1'b1; r[i] = 1'b0; end
    end
    return {r, yy, g, m_kind != K_IDLE,
            (m_kind == K_GREEN || m_kind == K_YELLOW) ? 1'(m_phase) : 1'(m_last)};
  endfunction

  function automatic bit lamp_ok_a(input logic [3:0] r, input logic [3:0] yy, input logic [3:0] g);
    for (int i = 0; i < 4; i++)
      if ({r[i], yy[i], g[i]} != 3'b100 && {r[i], yy[i], g[i]} != 3'b010 &&
          {r[i], yy[i], g[i]} != 3'b001) return 1'b0;
    if (!(g inside {4'h0, 4'h5, 4'hA}) || !(yy inside {4'h0, 4'h5, 4'hA})) return 1'b0;
    return 1'b1;
  endfunction

  task automatic cycle_a(input logic [3:0] t);
    traffic_a = t;
    model_advance(t);
    @(negedge clk);
  endtask

  task automatic apply_reset_a();
    rst_a = 1'b1; traffic_a = 4'h0;
    @(negedge clk);
    model_reset();
    rst_a = 1'b0;
  endtask

  task automatic test_reset();
    rst_a = 1'b0; rst_b = 1'b0; traffic_a = 4'h0; traffic_b = 8'h00;
    #1 rst_a = 1'b1; rst_b = 1'b1;
    #1;
    n_checks++;
    if ({red_a, yellow_a, green_a, busy_a, active_a} !== {4'hF, 4'h0, 4'h0, 1'b0, 1'b0})
      $display("FAIL reset_a got=%h required=%h", dut_a, {4'hF, 4'h0, 4'h0, 1'b0, 1'b0});
    else n_pass++;
    n_checks++;
    if ({red_b, yellow_b, green_b, busy_b, active_b} !== {8'hFF, 8'h00, 8'h00, 1'b0, 2'b00})
      $display("FAIL reset_b got=%h required=%h", {red_b, yellow_b, green_b, busy_b, active_b},
               {8'hFF, 8'h00, 8'h00, 1'b0, 2'b00});
    else n_pass++;
    @(negedge clk);
    model_reset();
    rst_a = 1'b0; rst_b = 1'b0;
  endtask

  task automatic test_single_pulse();
    int gc, yc, ac;
    gc = 0; yc = 0; ac = 0;
    cycle_a(4'b0001);
    n_checks++;
    if (busy_a !== 1'b1 || green_a !== 4'b0101)
      $display("FAIL pulse_first busy=%b green=%b required busy=1 green=0101", busy_a, green_a);
    else n_pass++;
    for (int k = 0; k < 70; k++) begin
      if (green_a == 4'b0101) gc++;
      if (yellow_a == 4'b0101) yc++;
      if (busy_a && green_a == 0 && yellow_a == 0) ac++;
      if ((green_a != 0 || yellow_a != 0)) begin
        n_checks++;
        if (red_a !== 4'b1010) $display("FAIL pulse_red got=%b required=1010", red_a);
        else n_pass++;
      end
      n_checks++;
      if (dut_a !== exp_vec()) $display("FAIL pulse_model t=%0t got=%h required=%h", $time, dut_a, exp_vec());
      else n_pass++;
      n_checks++;
      if (lamp_ok_a(red_a, yellow_a, green_a) !== 1'b1)
        $display("FAIL pulse_invariant r=%b y=%b g=%b", red_a, yellow_a, green_a);
      else n_pass++;
      if (k < 69) cycle_a(4'b0000);
    end
    n_checks++;
    if (gc != G || yc != Y || ac != AR || busy_a !== 1'b0)
      $display("FAIL pulse_durations got g=%0d y=%0d a=%0d busy=%b required g=%0d y=%0d a=%0d busy=0",
               gc, yc, ac, busy_a, G, Y, AR);
    else n_pass++;
  endtask

  task automatic test_alternate();
    int kind_prev, kind_now, run;
    int exp_len[4];
    int order[$];
    exp_len = '{1, G, Y, AR};
    kind_prev = -1; run = 0;
    apply_reset_a();
    for (int k = 0; k < 280; k++) begin
      cycle_a(4'hF);
      n_checks++;
      if (dut_a !== exp_vec()) $display("FAIL alt_model t=%0t got=%h required=%h", $time, dut_a, exp_vec());
      else n_pass++;
      n_checks++;
      if (lamp_ok_a(red_a, yellow_a, green_a) !== 1'b1)
        $display("FAIL alt_invariant r=%b y=%b g=%b", red_a, yellow_a, green_a);
      else n_pass++;
      kind_now = (green_a != 0) ? K_GREEN : (yellow_a != 0) ? K_YELLOW : busy_a ? K_ALLRED : K_IDLE;
      if (kind_now != kind_prev) begin
        if (kind_prev >= 0) begin
          n_checks++;
          if (run != exp_len[kind_prev])
            $display("FAIL alt_len kind=%0d got=%0d required=%0d", kind_prev, run, exp_len[kind_prev]);
          else n_pass++;
        end
        if (kind_now == K_GREEN) order.push_back(int'(active_a));
        kind_prev = kind_now; run = 1;
      end else run++;
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (order.size() <= i || order[i] != i % 2)
        $display("FAIL alt_order idx=%0d got=%0d required=%0d", i, (order.size() > i) ? order[i] : -1, i % 2);
      else n_pass++;
    end
  endtask

  task automatic test_rest_and_preempt();
    apply_reset_a();
    for (int k = 0; k < 100; k++) begin
      cycle_a(4'b0100);
      n_checks++;
      if (dut_a !== exp_vec()) $display("FAIL rest_model t=%0t got=%h required=%h", $time, dut_a, exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (green_a !== 4'b0101) $display("FAIL rest_green got=%b required=0101", green_a);
    else n_pass++;
    cycle_a(4'b0110);
    n_checks++;
    if (yellow_a !== 4'b0101) $display("FAIL preempt_yellow got=%b required=0101", yellow_a);
    else n_pass++;
    for (int k = 1; k <= 13; k++) begin
      cycle_a(4'b0100);
      n_checks++;
      if (dut_a !== exp_vec()) $display("FAIL preempt_model t=%0t got=%h required=%h", $time, dut_a, exp_vec());
      else n_pass++;
      if (k == 10 || k == 11) begin
        n_checks++;
        if (busy_a !== 1'b1 || red_a !== 4'hF) $display("FAIL preempt_allred busy=%b red=%b required 1/1111", busy_a, red_a);
        else n_pass++;
      end
      if (k == 12) begin
        n_checks++;
        if (busy_a !== 1'b0) $display("FAIL preempt_idle busy=%b required=0", busy_a);
        else n_pass++;
      end
      if (k == 13) begin
        n_checks++;
        if (green_a !== 4'b1010) $display("FAIL preempt_green got=%b required=1010", green_a);
        else n_pass++;
      end
    end
  endtask

  task automatic test_async_reset();
    apply_reset_a();
    cycle_a(4'b0001);
    for (int k = 1; k <= 59; k++) begin
      cycle_a((k == 10) ? 4'b0010 : 4'b0000);
      n_checks++;
      if (dut_a !== exp_vec()) $display("FAIL arst_model t=%0t got=%h required=%h", $time, dut_a, exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (yellow_a !== 4'b0101) $display("FAIL arst_yellow got=%b required=0101", yellow_a);
    else n_pass++;
    #2 rst_a = 1'b1;
    #1;
    n_checks++;
    if (dut_a !== {4'hF, 4'h0, 4'h0, 1'b0, 1'b0})
      $display("FAIL arst_immediate got=%h required=%h", dut_a, {4'hF, 4'h0, 4'h0, 1'b0, 1'b0});
    else n_pass++;
    @(negedge clk);
    model_reset();
    rst_a = 1'b0;
    for (int k = 0; k < 80; k++) begin
      cycle_a(4'b0000);
      n_checks++;
      if (busy_a !== 1'b0 || dut_a !== exp_vec())
        $display("FAIL arst_quiet t=%0t got=%h required=%h", $time, dut_a, exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [3:0] t;
    int hold;
    t = 4'h0; hold = 0;
    apply_reset_a();
    for (int k = 0; k < 600; k++) begin
      if (hold == 0) begin
        hold = $urandom_range(1, 8);
        t = ($urandom_range(0, 9) < 3) ? 4'h0 : 4'($urandom_range(0, 15));
      end
      hold--;
      cycle_a(t);
      n_checks++;
      if (dut_a !== exp_vec()) $display("FAIL rand_model t=%0t got=%h required=%h", $time, dut_a, exp_vec());
      else n_pass++;
      n_checks++;
      if (lamp_ok_a(red_a, yellow_a, green_a) !== 1'b1)
        $display("FAIL rand_invariant r=%b y=%b g=%b", red_a, yellow_a, green_a);
      else n_pass++;
    end
  endtask

  task automatic test_four_phase();
    int c, allred_cycles, bad_lamps;
    int order[$];
    logic [7:0] g3;
    bit prev_green;
    rst_b = 1'b1; traffic_b = 8'h00;
    @(negedge clk);
    rst_b = 1'b0;
    traffic_b = 8'h02;
    @(negedge clk);
    traffic_b = 8'h00;
    n_checks++;
    if (green_b !== 8'b0010_0010 || active_b !== 2'd1)
      $display("FAIL four_first green=%b active=%0d required 00100010/1", green_b, active_b);
    else n_pass++;
    c = 0;
    while (busy_b && c < 40) begin @(negedge clk); c++; end
    n_checks++;
    if (busy_b !== 1'b0) $display("FAIL four_drain_timeout busy=%b required=0", busy_b);
    else n_pass++;
    traffic_b = 8'b0000_1011;
    @(negedge clk);
    traffic_b = 8'h00;
    allred_cycles = 0; bad_lamps = 0; prev_green = 1'b0; g3 = 8'h00;
    for (int k = 0; k < 40; k++) begin
      if (green_b != 0 && !prev_green) begin
        order.push_back(int'(active_b));
        if (active_b == 2'd3) g3 = green_b;
      end
      prev_green = (green_b != 0);
      if (busy_b && green_b == 0 && yellow_b == 0) allred_cycles++;
      for (int i = 0; i < 8; i++)
        if (int'(red_b[i]) + int'(yellow_b[i]) + int'(green_b[i]) != 1) bad_lamps++;
      if (!(green_b inside {8'h00, 8'h11, 8'h22, 8'h44, 8'h88})) bad_lamps++;
      @(negedge clk);
    end
    n_checks++;
    if (order.size() != 3 || order[0] != 3 || order[1] != 0 || order[2] != 1)
      $display("FAIL four_order got size=%0d first=%0d required 3,0,1", order.size(),
               (order.size() > 0) ? order[0] : -1);
    else n_pass++;
    n_checks++;
    if (g3 !== 8'b1000_1000) $display("FAIL four_mask got=%b required=10001000", g3);
    else n_pass++;
    n_checks++;
    if (allred_cycles != 0) $display("FAIL four_no_allred got=%0d required=0", allred_cycles);
    else n_pass++;
    n_checks++;
    if (bad_lamps != 0) $display("FAIL four_invariant got=%0d required=0", bad_lamps);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_alternate();
    test_rest_and_preempt();
    test_async_reset();
    test_random();
    test_four_phase();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/traffic_phase_controller.md
# traffic_phase_controller

Parametrised multi-phase intersection controller: NUM_LANES lane-demand inputs mapped onto NUM_PHASES signal phases. It latches demand per phase, serves phases round-robin, and sequences each through GREEN, YELLOW and an optional ALL-RED clearance. Green rests on the served phase while it alone has demand. It is the top-level signal sequencer of the traffic subsystem, driving the per-lane red/yellow/green lamp outputs.

## Interface
- NUM_LANES, 4, number of lane demand inputs and lamp outputs
- NUM_PHASES, 2, number of phases; lane i belongs to phase i % NUM_PHASES; 2..8
- GREEN_TIME, 55, minimum green duration in cycles, ≥1
- YELLOW_TIME, 10, yellow duration in cycles, ≥1
- ALLRED_TIME, 2, all-red clearance after yellow in cycles, ≥0 (0 = skipped)
- TW, $clog2(max(GREEN_TIME,YELLOW_TIME,ALLRED_TIME)+1), timer width (derived localparam)
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- traffic  input  NUM_LANES  per-lane vehicle demand, level, synchronous to clk
- red  output  NUM_LANES  red lamp per lane
- yellow  output  NUM_LANES  yellow lamp per lane
- green  output  NUM_LANES  green lamp per lane
- active_phase  output  $clog2(NUM_PHASES)  phase currently in GREEN/YELLOW (last served phase in IDLE/ALLRED)
- busy  output  1  high in any state other than IDLE

## Operation
- States: IDLE, GREEN, YELLOW, ALLRED. Registers: state, cur (served phase), last (last served phase), timer[TW-1:0], pend[NUM_PHASES-1:0].
- Phase demand: dem[p] = OR of traffic[i] over lanes with i % NUM_PHASES == p.
- Pending latch: each edge, pend[p] <= pend[p] | dem[p], with one exception: on the edge entering GREEN for phase p, pend[p] <= 0. Demand from p during its own GREEN is not latched. Demand from p during its YELLOW/ALLRED is latched.
- Selection: round-robin. The first p with (pend|dem)[p] set, searching from (last+1) mod NUM_PHASES upward with wrap.
- IDLE: if any (pend|dem) is set, go to GREEN with cur = selected phase and timer = GREEN_TIME-1. Otherwise stay in IDLE.
- GREEN: timer decrements to 0 and holds at 0. At timer==0:
  - If another phase q≠cur has (pend|dem)[q] set, go to YELLOW with timer = YELLOW_TIME-1.
  - Else if dem[cur] is set, rest in GREEN.
  - Else go to YELLOW.
- YELLOW: at timer==0, record last = cur. Then go to ALLRED with timer = ALLRED_TIME-1, or go straight to IDLE if ALLRED_TIME==0.
- ALLRED: at timer==0, go to IDLE.
- IDLE→GREEN for a newly selected phase therefore costs exactly one IDLE cycle.
- Lamps (Moore, decoded from registered state/cur):
  - In GREEN, lanes of cur are green and all other lanes red.
  - In YELLOW, lanes of cur are yellow and all other lanes red.
  - In IDLE/ALLRED, all lanes are red.
- Invariant: exactly one of red/yellow/green is high per lane every cycle. Green/yellow are never high on two phases at once.
- Arithmetic: the timer is unsigned TW bits and never underflows (held at 0).

## Timing
- Reset (async, immediate, including mid-GREEN/YELLOW):
  - state=IDLE, cur=0, last=NUM_PHASES-1, timer=0, pend=0.
  - red=all ones, green=0, yellow=0, active_phase=0, busy=0.
  - Outputs change without waiting for clk.
- First edge after reset release with dem[0] high: GREEN phase 0. Phase 0 wins ties after reset.
- Green lasts exactly GREEN_TIME cycles when it is not resting; yellow lasts exactly YELLOW_TIME cycles; all-red lasts exactly ALLRED_TIME cycles.
- Traffic pulse of 1 cycle in any state: captured in pend and served later. It is dropped only if it belongs to cur during GREEN.
- Simultaneous demand on all phases: served in order last+1, last+2, … with no phase served twice before every pending phase is served once.
- Traffic dropping during GREEN with timer>0: no early termination. Minimum green is always honoured.

## Structure
- Package traffic_pkg: state enum (IDLE, GREEN, YELLOW, ALLRED), function lane_phase(i, NUM_PHASES), function to build a phase lane mask.
- Sub-module phase_rr_arbiter: parameter N; inputs req[N-1:0] and last; outputs grant index and any. It is purely combinational rotate-priority logic and is reused by the pedestrian extension.
- The controller keeps the FSM, timer, pend latch and lamp decode. Target size is 150-250 lines.

## Test plan
- Defaults, reset then traffic=4'b0001 held for 1 cycle:
  - busy rises next edge; green=0101 for 55 cycles, then yellow=0101 for 10, then all red for 2, then IDLE.
  - red=1010 throughout green and yellow.
- traffic=4'b1111 held constant: phases alternate 0,1,0,1.
  - Each green is exactly 55 cycles; each yellow 10, all-red 2, IDLE 1 between phases.
- traffic=4'b0100 held constant: green=0101 persists indefinitely past 55 cycles.
  - Then pulse traffic[1] for 1 cycle: yellow=0101 on the next cycle, followed by all-red 2 and IDLE 1, then green=1010.
- NUM_PHASES=4, NUM_LANES=8, ALLRED_TIME=0, last=1, traffic pulse on lanes 0,1,3:
  - Served order is 3, 0, 1.
  - YELLOW goes directly to IDLE with no all-red cycles.
- Assert rst asynchronously mid-yellow (timer=5):
  - Outputs go to red=all ones within the same cycle; pend cleared; no phase served after release without new traffic.
- Every run: per-lane one-hot lamp invariant checked each cycle; no two phases green simultaneously.
